// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready skid buffer that registers in_ready,
// so downstream back-pressure never reaches upstream combinationally.
// Sustains one transfer per clock with one cycle of latency.
//
// Optional feature macro: PIPE_SKID_STATS_EN adds the occ and stall_cnt ports.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   flush               synchronous flush that discards all buffered entries
//   in_valid/in_ready   upstream handshake; in_ready is registered
//   in_data             upstream payload
//   out_valid/out_ready downstream handshake; out_valid is registered
//   out_data            payload from the main register
//   occ                 [stats] number of entries held, 0..2
//   stall_cnt           [stats] saturating count of back-pressure cycles
module pipe_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [1:0]       occ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Next state and storage updates; flush overrides every transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Skid always holds the younger entry, so it refills main.
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Handshake flags are decoded from the next state and then registered.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

`ifdef PIPE_SKID_STATS_EN
  logic [1:0]  occ_q, occ_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Occupancy follows the next state; stall counter saturates and clears on flush.
  always_comb begin
    occ_d       = occ_q;
    stall_cnt_d = stall_cnt_q;
    case (state_d)
      ST_EMPTY: occ_d = 2'd0;
      ST_BUSY:  occ_d = 2'd1;
      ST_FULL:  occ_d = 2'd2;
      default:  occ_d = 2'd0;
    endcase
    if (flush) begin
      stall_cnt_d = 16'd0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= 2'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign occ       = occ_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
